uart_rx_deframer: RTL
=====================

// Module: uart_rx_deframer
// PURPOSE
//  Receive side of the UART link. Oversamples the serial line, detects the start bit,
//  majority-votes each bit, and deserialises LSB-first data. Checks optional parity and
//  the stop bit. Presents one parallel word per frame to the consuming logic.
//  Frame format matches the TX path: start(0), DATA_WIDTH data bits, optional parity, stop(1).
// PARAMETERS
//  DATA_WIDTH   8   data bits per frame
//  PRESCALE_W   6   width of prescale input (oversampling ratio up to 2**PRESCALE_W-1)
// PORTS
//  clk         in   1           system clock, rising edge
//  rst         in   1           asynchronous, active-low reset
//  rx_in       in   1           serial line, asynchronous to clk, idle high
//  prescale    in   PRESCALE_W  clk cycles per bit; legal values are even and >= 8 (8/16/32 tested)
//  par_en      in   1           1 = parity bit present in frame
//  par_typ     in   1           0 = even, 1 = odd parity
//  p_data      out  DATA_WIDTH  last correctly received word (registered)
//  data_valid  out  1           one-cycle pulse: p_data updated with a good frame
//  par_err     out  1           one-cycle pulse: parity mismatch, frame dropped
//  stp_err     out  1           one-cycle pulse: stop bit sampled 0, frame dropped
//  busy        out  1           high from start detection until return to IDLE
// BEHAVIOUR
//  - Reset: p_data=0, data_valid/par_err/stp_err/busy=0, FSM=IDLE, sync flops=1, armed=0.
//    Reset mid-frame discards the partial frame with no output pulse.
//  - rx_in passes through a 2-flop synchroniser (reset value 1). All logic uses the synced bit.
//  - prescale, par_en and par_typ are captured on start detection. Changes mid-frame are ignored.
//  - Bit timing: smp_cnt runs 0..prescale-1 per bit.
//    * Samples are taken at P/2-1, P/2 and P/2+1, where P is the captured prescale.
//    * The bit value is the 2-of-3 majority, resolved at smp_cnt=P/2+1.
//  - FSM states: IDLE, START, DATA, PARITY, STOP.
//    * IDLE: armed is set once the synced line is seen high. If armed and the line is 0:
//      go to START, clear smp_cnt, set busy.
//    * START: if the majority is 1 (glitch), go to IDLE, drop busy, pulse nothing.
//      Otherwise go to DATA at smp_cnt=P-1.
//    * DATA: shift the majority bit in at bit 0 first (LSB first); bit_cnt runs 0..DATA_WIDTH-1.
//      After the last bit, go to PARITY if par_en, else STOP.
//    * PARITY: expected bit = ^data XOR par_typ. Store the mismatch flag. Go to STOP at smp_cnt=P-1.
//    * STOP: at majority resolution, go directly to IDLE (half-bit early, so that back-to-back
//      frames resync on the next start edge). busy drops in the same cycle.
//  - Outputs are registered and asserted in the cycle after the stop-bit majority edge:
//    * stop=0: stp_err=1 only (stop error takes priority over a parity error). armed is cleared,
//      so a held-low line (break) yields exactly one stp_err and no further frames until it
//      returns high.
//    * stop=1 with parity mismatch: par_err=1 only.
//    * otherwise: data_valid=1 and p_data <= shift register.
//    * p_data holds its value on error frames.
//  - At most one of data_valid/par_err/stp_err is high in any cycle.
//  - Each pulse lasts exactly one clk.
//  - Counters never wrap mid-bit. smp_cnt clears on every bit boundary and on entry to START.
// STRUCTURE
//  - Shared include uart_defs.vh holds:
//    * FSM state encodings (shared with the TX FSM)
//    * PAR_EVEN=1'b0, PAR_ODD=1'b1
//    * default DATA_WIDTH
//  - Sub-module uart_rx_sampler holds the smp_cnt counter, 3-sample capture and majority vote.
//    It outputs bit_val, bit_rdy (majority resolved) and bit_end (smp_cnt=P-1).
//  - Top level holds the synchroniser, the FSM, bit_cnt, the shift register, parity and the
//    output registers.
// TESTING  (DATA_WIDTH=8, prescale=16 unless noted)
//  1. 0xA5, par_en=0 -> single data_valid pulse, p_data=0xA5, par_err=stp_err=0, busy low after.
//  2. 0x3C, par_en=1 even, parity bit 0 -> data_valid, p_data=0x3C.
//     Same frame with parity bit 1 -> par_err pulse, no data_valid, p_data stays 0x3C.
//  3. 0x81 with stop bit 0, then line held low 40 bit times -> exactly one stp_err,
//     no further pulses; after the line returns high, frame 0x55 -> data_valid, p_data=0x55.
//  4. Start glitch low for 4 clk then high -> busy pulses, no data_valid/par_err/stp_err,
//     next frame 0x12 received correctly.
//  5. prescale=8, back-to-back 0x00 then 0xFF with zero idle gap, par_en=1 odd
//     -> two data_valid pulses with p_data 0x00 then 0xFF.
//  6. rst low mid-DATA of 0xC3 -> all outputs 0 immediately; after release, frame 0x7E
//     -> data_valid, p_data=0x7E.

Source files
------------

// File: rtl/uart_rx_deframer_pkg.sv
// Shared UART definitions: FSM state encodings, parity types, default widths and a vote helper.
package uart_rx_deframer_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_PRESCALE_W = 6;

  typedef enum logic {
    PAR_EVEN = 1'b0,
    PAR_ODD  = 1'b1
  } par_type_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_deframer_sampler.sv
// Per-bit sample counter, three-point capture around mid-bit and 2-of-3 majority vote.
module uart_rx_deframer_sampler
  import uart_rx_deframer_pkg::*;
#(
  parameter int unsigned PRESCALE_W = DEF_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clear,
  input  logic                  i_run,
  input  logic                  i_rx,
  input  logic [PRESCALE_W-1:0] i_prescale,
  output logic                  o_bit_val_c,
  output logic                  o_bit_rdy_c,
  output logic                  o_bit_end_c
);

  logic [PRESCALE_W-1:0] r_smp_cnt;
  logic                  r_s0;
  logic                  r_s1;
  logic [PRESCALE_W-1:0] w_half;
  logic [PRESCALE_W-1:0] w_last;

  assign w_half = i_prescale >> 1;
  assign w_last = i_prescale - PRESCALE_W'(1);

  // Counter wraps at P-1 so every bit boundary restarts it from zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_smp_cnt <= '0;
      r_s0      <= 1'b1;
      r_s1      <= 1'b1;
    end else if (i_clear) begin
      r_smp_cnt <= '0;
    end else if (i_run) begin
      if (r_smp_cnt == w_last) r_smp_cnt <= '0;
      else                     r_smp_cnt <= r_smp_cnt + PRESCALE_W'(1);
      if (r_smp_cnt == w_half - PRESCALE_W'(1)) r_s0 <= i_rx;
      if (r_smp_cnt == w_half)                  r_s1 <= i_rx;
    end
  end

  // Third sample is the live line at P/2+1, so the vote resolves in that cycle.
  assign o_bit_val_c = maj3(r_s0, r_s1, i_rx);
  assign o_bit_rdy_c = i_run && (r_smp_cnt == w_half + PRESCALE_W'(1));
  assign o_bit_end_c = i_run && (r_smp_cnt == w_last);

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: synchroniser, frame FSM, deserialiser, parity/stop checks, output pulses.
module uart_rx_deframer
  import uart_rx_deframer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned PRESCALE_W = DEF_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_rx_in,
  input  logic [PRESCALE_W-1:0] i_prescale,
  input  logic                  i_par_en,
  input  logic                  i_par_typ,
  output logic [DATA_WIDTH-1:0] o_p_data,
  output logic                  o_data_valid,
  output logic                  o_par_err,
  output logic                  o_stp_err,
  output logic                  o_busy
);

  localparam int unsigned BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  uart_state_e           r_state, w_state_nxt;
  logic                  r_sync1, r_sync2;
  logic                  r_armed, w_armed_nxt;
  logic                  r_busy, w_busy_nxt;
  logic [BCW-1:0]        r_bit_cnt, w_bit_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_shift, w_shift_nxt;
  logic                  r_par_bad, w_par_bad_nxt;
  logic [PRESCALE_W-1:0] r_prescale, w_prescale_nxt;
  logic                  r_par_en, w_par_en_nxt;
  logic                  r_par_typ, w_par_typ_nxt;
  logic [DATA_WIDTH-1:0] r_p_data, w_p_data_nxt;
  logic                  r_data_valid, w_data_valid_nxt;
  logic                  r_par_err, w_par_err_nxt;
  logic                  r_stp_err, w_stp_err_nxt;
  logic                  w_rx;
  logic                  w_start_det;
  logic                  w_bit_val, w_bit_rdy, w_bit_end;

  assign w_rx = r_sync2;

  uart_rx_deframer_sampler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_sampler (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (w_start_det),
    .i_run       (r_state != ST_IDLE),
    .i_rx        (w_rx),
    .i_prescale  (r_prescale),
    .o_bit_val_c (w_bit_val),
    .o_bit_rdy_c (w_bit_rdy),
    .o_bit_end_c (w_bit_end)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1      <= 1'b1;
      r_sync2      <= 1'b1;
      r_state      <= ST_IDLE;
      r_armed      <= 1'b0;
      r_busy       <= 1'b0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_par_bad    <= 1'b0;
      r_prescale   <= '0;
      r_par_en     <= 1'b0;
      r_par_typ    <= 1'b0;
      r_p_data     <= '0;
      r_data_valid <= 1'b0;
      r_par_err    <= 1'b0;
      r_stp_err    <= 1'b0;
    end else begin
      r_sync1      <= i_rx_in;
      r_sync2      <= r_sync1;
      r_state      <= w_state_nxt;
      r_armed      <= w_armed_nxt;
      r_busy       <= w_busy_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_shift      <= w_shift_nxt;
      r_par_bad    <= w_par_bad_nxt;
      r_prescale   <= w_prescale_nxt;
      r_par_en     <= w_par_en_nxt;
      r_par_typ    <= w_par_typ_nxt;
      r_p_data     <= w_p_data_nxt;
      r_data_valid <= w_data_valid_nxt;
      r_par_err    <= w_par_err_nxt;
      r_stp_err    <= w_stp_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_armed_nxt      = r_armed;
    w_busy_nxt       = r_busy;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_shift_nxt      = r_shift;
    w_par_bad_nxt    = r_par_bad;
    w_prescale_nxt   = r_prescale;
    w_par_en_nxt     = r_par_en;
    w_par_typ_nxt    = r_par_typ;
    w_p_data_nxt     = r_p_data;
    w_data_valid_nxt = 1'b0;
    w_par_err_nxt    = 1'b0;
    w_stp_err_nxt    = 1'b0;
    w_start_det      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_rx) w_armed_nxt = 1'b1;
        if (r_armed && !w_rx) begin
          w_start_det    = 1'b1;
          w_state_nxt    = ST_START;
          w_busy_nxt     = 1'b1;
          w_bit_cnt_nxt  = '0;
          w_par_bad_nxt  = 1'b0;
          w_prescale_nxt = i_prescale;
          w_par_en_nxt   = i_par_en;
          w_par_typ_nxt  = i_par_typ;
        end
      end
      ST_START: begin
        if (w_bit_rdy && w_bit_val) begin
          w_state_nxt = ST_IDLE;
          w_busy_nxt  = 1'b0;
        end else if (w_bit_end) begin
          w_state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_bit_rdy) w_shift_nxt = {w_bit_val, r_shift[DATA_WIDTH-1:1]};
        if (w_bit_end) begin
          if (r_bit_cnt == BCW'(DATA_WIDTH - 1)) begin
            w_bit_cnt_nxt = '0;
            w_state_nxt   = r_par_en ? ST_PARITY : ST_STOP;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + BCW'(1);
          end
        end
      end
      ST_PARITY: begin
        if (w_bit_rdy) w_par_bad_nxt = w_bit_val ^ (^r_shift) ^ (r_par_typ == PAR_ODD);
        if (w_bit_end) w_state_nxt = ST_STOP;
      end
      ST_STOP: begin
        // Leave half a bit early so the next start edge is caught promptly.
        if (w_bit_rdy) begin
          w_state_nxt = ST_IDLE;
          w_busy_nxt  = 1'b0;
          if (!w_bit_val) begin
            w_stp_err_nxt = 1'b1;
            w_armed_nxt   = 1'b0;
          end else if (r_par_bad) begin
            w_par_err_nxt = 1'b1;
          end else begin
            w_data_valid_nxt = 1'b1;
            w_p_data_nxt     = r_shift;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign o_p_data     = r_p_data;
  assign o_data_valid = r_data_valid;
  assign o_par_err    = r_par_err;
  assign o_stp_err    = r_stp_err;
  assign o_busy       = r_busy;

endmodule
